// File: rtl/uart_rx_configurable.sv
`timescale 1ns/1ps
// uart_rx_configurable: oversampling UART receiver, mid-bit sampling,
// configurable data width, parity mode and stop-bit count.
// Ports:
//   i_CLK        clock, rising edge
//   i_RST_N      async active-low reset
//   i_RX         async serial line, idle high
//   o_DATA       last data word, held until next o_RX_DONE
//   o_RX_DONE    one-cycle pulse per completed frame
//   o_PARITY_ERR parity mismatch of last frame
//   o_FRAME_ERR  low stop bit seen in last frame
//   o_BUSY       receiver not idle
module uart_rx_configurable #(
  parameter int P_CLKS_PER_BIT = 16,
  parameter int P_DATA_BITS    = 8,
  parameter int P_PARITY       = 0,
  parameter int P_STOP_BITS    = 1
) (
  input  logic                   i_CLK,
  input  logic                   i_RST_N,
  input  logic                   i_RX,
  output logic [P_DATA_BITS-1:0] o_DATA,
  output logic                   o_RX_DONE,
  output logic                   o_PARITY_ERR,
  output logic                   o_FRAME_ERR,
  output logic                   o_BUSY
);

  localparam int CW = $clog2(P_CLKS_PER_BIT);
  localparam int BW = $clog2(P_DATA_BITS + 1);
  localparam int H  = P_CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] C_MID = CW'(H - 1);
  localparam logic [CW-1:0] C_END = CW'(P_CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_DLAST = BW'(P_DATA_BITS - 1);
  localparam logic [BW-1:0] B_SLAST = BW'(P_STOP_BITS - 1);

  localparam bit HAS_PAR = (P_PARITY != 0);
  localparam bit ODD_PAR = (P_PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e state_q, state_d;

  logic [1:0]             sync_q;
  logic                   rx_s;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [P_DATA_BITS-1:0] sh_q, sh_d;
  logic                   xor_q, xor_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic [P_DATA_BITS-1:0] data_q, data_d;
  logic                   done_q, done_d;
  logic                   perr_o_q, perr_o_d;
  logic                   ferr_o_q, ferr_o_d;

  logic at_mid;
  logic at_end;
  logic par_x;
  logic ferr_now;
  logic [CW-1:0] cnt_inc;

  assign rx_s     = sync_q[1];
  assign at_mid   = (cnt_q == C_MID);
  assign at_end   = (cnt_q == C_END);
  assign cnt_inc  = cnt_q + CW'(1);
  assign par_x    = xor_q ^ rx_s;
  assign ferr_now = ferr_q | ~rx_s;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      sync_q   <= 2'b11;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      xor_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
      perr_o_q <= 1'b0;
      ferr_o_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], i_RX};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      xor_q    <= xor_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      data_q   <= data_d;
      done_q   <= done_d;
      perr_o_q <= perr_o_d;
      ferr_o_q <= ferr_o_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    xor_d    = xor_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    data_d   = data_q;
    done_d   = 1'b0;
    perr_o_d = perr_o_q;
    ferr_o_d = ferr_o_q;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (at_mid) begin
          if (!rx_s) begin
            state_d = S_DATA;
            cnt_d   = '0;
            bit_d   = '0;
            xor_d   = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DATA: begin
        if (at_end) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[P_DATA_BITS-1:1]};
          xor_d = xor_q ^ rx_s;
          if (bit_q == B_DLAST) begin
            bit_d   = '0;
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_PARITY: begin
        if (at_end) begin
          cnt_d   = '0;
          perr_d  = ODD_PAR ? ~par_x : par_x;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_STOP: begin
        if (at_end) begin
          cnt_d  = '0;
          ferr_d = ferr_now;
          if (bit_q == B_SLAST) begin
            bit_d    = '0;
            data_d   = sh_q;
            perr_o_d = HAS_PAR & perr_q;
            ferr_o_d = ferr_now;
            done_d   = 1'b1;
            // a low stop usually means a break; wait for the
            // line to rise so it cannot look like a new start
            state_d  = ferr_now ? S_WAIT_HIGH : S_IDLE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_DATA       = data_q;
  assign o_RX_DONE    = done_q;
  assign o_PARITY_ERR = perr_o_q;
  assign o_FRAME_ERR  = ferr_o_q;
  assign o_BUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_configurable.sv
`timescale 1ns/1ps
// tb_uart_rx_configurable: scoreboard bench over five receiver
// configurations, directed scenarios plus random frames.
module tb_uart_rx_configurable;

  localparam int N = 5;
  localparam int CPB [N] = '{16, 16, 16, 5, 4};
  localparam int DBT [N] = '{8, 8, 7, 9, 5};
  localparam int PAR [N] = '{0, 2, 0, 1, 2};
  localparam int SBT [N] = '{1, 1, 2, 2, 1};

  logic clk = 1'b0;
  logic rst_n;
  logic rx [N];
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [8:0] d3;
  logic [4:0] d4;
  logic [8:0] dat [N];
  logic done [N];
  logic perr [N];
  logic ferr [N];
  logic busy [N];

  always_comb begin
    dat[0] = 9'(d0);
    dat[1] = 9'(d1);
    dat[2] = 9'(d2);
    dat[3] = d3;
    dat[4] = 9'(d4);
  end

  uart_rx_configurable #(
    .P_CLKS_PER_BIT(CPB[0]), .P_DATA_BITS(DBT[0]),
    .P_PARITY(PAR[0]), .P_STOP_BITS(SBT[0])
  ) u0 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_RX(rx[0]),
    .o_DATA(d0), .o_RX_DONE(done[0]),
    .o_PARITY_ERR(perr[0]), .o_FRAME_ERR(ferr[0]),
    .o_BUSY(busy[0])
  );
  uart_rx_configurable #(
    .P_CLKS_PER_BIT(CPB[1]), .P_DATA_BITS(DBT[1]),
    .P_PARITY(PAR[1]), .P_STOP_BITS(SBT[1])
  ) u1 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_RX(rx[1]),
    .o_DATA(d1), .o_RX_DONE(done[1]),
    .o_PARITY_ERR(perr[1]), .o_FRAME_ERR(ferr[1]),
    .o_BUSY(busy[1])
  );
  uart_rx_configurable #(
    .P_CLKS_PER_BIT(CPB[2]), .P_DATA_BITS(DBT[2]),
    .P_PARITY(PAR[2]), .P_STOP_BITS(SBT[2])
  ) u2 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_RX(rx[2]),
    .o_DATA(d2), .o_RX_DONE(done[2]),
    .o_PARITY_ERR(perr[2]), .o_FRAME_ERR(ferr[2]),
    .o_BUSY(busy[2])
  );
  uart_rx_configurable #(
    .P_CLKS_PER_BIT(CPB[3]), .P_DATA_BITS(DBT[3]),
    .P_PARITY(PAR[3]), .P_STOP_BITS(SBT[3])
  ) u3 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_RX(rx[3]),
    .o_DATA(d3), .o_RX_DONE(done[3]),
    .o_PARITY_ERR(perr[3]), .o_FRAME_ERR(ferr[3]),
    .o_BUSY(busy[3])
  );
  uart_rx_configurable #(
    .P_CLKS_PER_BIT(CPB[4]), .P_DATA_BITS(DBT[4]),
    .P_PARITY(PAR[4]), .P_STOP_BITS(SBT[4])
  ) u4 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_RX(rx[4]),
    .o_DATA(d4), .o_RX_DONE(done[4]),
    .o_PARITY_ERR(perr[4]), .o_FRAME_ERR(ferr[4]),
    .o_BUSY(busy[4])
  );

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    longint     due;
  } exp_t;

  exp_t   sbq [N][$];
  int     n_chk = 0;
  int     n_fail = 0;
  longint prev_done [N];
  longint last_done [N];
  logic   done_d1 [N];

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               nm, got, exp);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int d = 0; d < N; d++) s += sbq[d].size();
    return s;
  endfunction

  // Reference frame builder: line levels come from the framing
  // rules, completion time from the mid-bit sampling schedule.
  task automatic send_frame(input int d,
                            input logic [8:0] data,
                            input bit bad_par,
                            input int bad_stop);
    bit bits[$];
    exp_t e;
    logic [8:0] m;
    bit pb;
    int c;
    c = CPB[d];
    m = data & 9'((1 << DBT[d]) - 1);
    bits.push_back(1'b0);
    for (int i = 0; i < DBT[d]; i++) bits.push_back(m[i]);
    if (PAR[d] != 0) begin
      pb = (PAR[d] == 2) ? ^m : ~^m;
      if (bad_par) pb = ~pb;
      bits.push_back(pb);
    end
    for (int s = 0; s < SBT[d]; s++)
      bits.push_back(s != bad_stop);
    e.data = m;
    e.pe   = (PAR[d] != 0) && bad_par;
    e.fe   = (bad_stop >= 0) && (bad_stop < SBT[d]);
    e.due  = cyc + 3 + c / 2 + longint'(bits.size() - 1) * c;
    sbq[d].push_back(e);
    foreach (bits[i]) begin
      rx[d] = bits[i];
      repeat (c) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int d, input int n);
    rx[d] = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (pending() > 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", pending(), 0);
  endtask

  task automatic rand_run(input int d, input int nfr);
    logic [8:0] v;
    bit bp;
    int bs;
    int g;
    for (int k = 0; k < nfr; k++) begin
      v  = 9'($urandom);
      bp = ($urandom_range(0, 4) == 0);
      bs = -1;
      if ($urandom_range(0, 5) == 0)
        bs = $urandom_range(0, SBT[d] - 1);
      send_frame(d, v, bp, bs);
      g = $urandom_range(0, 3 * CPB[d]);
      if (bs == SBT[d] - 1 && g < 4) g = 4;
      if (g > 0) idle(d, g);
    end
    idle(d, 2 * CPB[d]);
  endtask

  initial begin
    exp_t e;
    for (int d = 0; d < N; d++) begin
      done_d1[d] = 1'b0;
      prev_done[d] = 0;
      last_done[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
        if (rst_n === 1'b1 && done[d] === 1'b1) begin
          chk($sformatf("dut%0d_pulse_width", d), done_d1[d], 0);
          chk($sformatf("dut%0d_expected_pending", d),
              sbq[d].size() > 0, 1);
          if (sbq[d].size() > 0) begin
            e = sbq[d].pop_front();
            chk($sformatf("dut%0d_data", d), dat[d], e.data);
            chk($sformatf("dut%0d_parity_err", d), perr[d], e.pe);
            chk($sformatf("dut%0d_frame_err", d), ferr[d], e.fe);
            chk($sformatf("dut%0d_done_cycle", d), cyc, e.due);
            chk($sformatf("dut%0d_busy_at_done", d), busy[d], e.fe);
          end
          prev_done[d] = last_done[d];
          last_done[d] = cyc;
        end
        done_d1[d] = (rst_n === 1'b1) ? done[d] : 1'b0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    for (int d = 0; d < N; d++) rx[d] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) begin
      chk($sformatf("rst%0d_data", d), dat[d], 0);
      chk($sformatf("rst%0d_done", d), done[d], 0);
      chk($sformatf("rst%0d_perr", d), perr[d], 0);
      chk($sformatf("rst%0d_ferr", d), ferr[d], 0);
      chk($sformatf("rst%0d_busy", d), busy[d], 0);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send_frame(0, 9'h0A5, 1'b0, -1);
    idle(0, 20);
    wait_drain(300);

    rx[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("false_start_busy_high", busy[0], 1);
    rx[0] = 1'b1;
    n = 0;
    while (busy[0] !== 1'b0 && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("false_start_busy_low", busy[0], 0);
    idle(0, 40);

    send_frame(0, 9'h03C, 1'b0, 0);
    rx[0] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("break_busy_held", busy[0], 1);
    idle(0, 20);
    send_frame(0, 9'h081, 1'b0, -1);
    idle(0, 20);
    wait_drain(300);

    send_frame(1, 9'h007, 1'b0, -1);
    idle(1, 20);
    send_frame(1, 9'h007, 1'b1, -1);
    idle(1, 20);
    wait_drain(300);

    send_frame(2, 9'h000, 1'b0, -1);
    send_frame(2, 9'h07F, 1'b0, -1);
    idle(2, 20);
    wait_drain(400);
    chk("b2b_spacing", last_done[2] - prev_done[2], 160);

    fork
      rand_run(0, 25);
      rand_run(1, 25);
      rand_run(2, 25);
      rand_run(3, 40);
      rand_run(4, 40);
    join
    wait_drain(2000);

    rx[0] = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rx[0] = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    rx[0] = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rx[0] = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    rx[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("midframe_busy", busy[0], 1);
    rst_n = 1'b0;
    rx[0] = 1'b1;
    #1;
    chk("midrst_data", dat[0], 0);
    chk("midrst_done", done[0], 0);
    chk("midrst_perr", perr[0], 0);
    chk("midrst_ferr", ferr[0], 0);
    chk("midrst_busy", busy[0], 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(0, 64);
    send_frame(0, 9'h0C3, 1'b0, -1);
    idle(0, 20);
    wait_drain(300);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_configurable.md
# uart_rx_configurable

Parametrised UART receiver, successor to the fixed 8-bit `uart_receiver` in `INTERFACES/UART/RECEIVER`. It oversamples `i_RX` with a clocks-per-bit divider and samples each bit at mid-bit. Data width, parity mode and stop-bit count are configurable. Each received frame is reported as a one-cycle `o_RX_DONE` pulse, with parity and framing error flags. The block sits between the pad-side RX line and the host-side byte consumer.

## Interface
- `P_CLKS_PER_BIT`, default 16: `i_CLK` cycles per UART bit; legal range ≥ 4.
- `P_DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `P_PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `P_STOP_BITS`, default 1: stop bits per frame; 1 or 2.
- `i_CLK` input, 1 bit: sole clock; all flops on its rising edge.
- `i_RST_N` input, 1 bit: reset, asynchronous assert, active-low.
- `i_RX` input, 1 bit: asynchronous serial line, idle high.
- `o_DATA` output, `P_DATA_BITS` bits: last received data word, LSB first on the line. Held until the next `o_RX_DONE`.
- `o_RX_DONE` output, 1 bit: one-cycle pulse when a frame completes (good or errored).
- `o_PARITY_ERR` output, 1 bit: parity mismatch for the frame; valid with and held after `o_RX_DONE`. Always 0 when `P_PARITY`=0.
- `o_FRAME_ERR` output, 1 bit: a stop bit was sampled low; valid with and held after `o_RX_DONE`.
- `o_BUSY` output, 1 bit: high in every state except IDLE.

## Operation
- **Synchroniser**: `i_RX` passes through a 2-flop synchroniser. Both flops reset to 1. Its output is called `rx_s`.
- **Counters**:
  - Clock counter: width `$clog2(P_CLKS_PER_BIT)`.
  - Bit counter: width `$clog2(P_DATA_BITS+1)`.
  - Shift register: `P_DATA_BITS` wide, shifts right, new bit enters at the MSB.
- **Constant**: H = `P_CLKS_PER_BIT`/2 (integer division).
- **IDLE**: on `rx_s`=0, go to START and clear the clock counter.
- **START**:
  - At clock count H-1, sample `rx_s`.
  - If 0: go to DATA and clear both counters.
  - If 1 (glitch or false start): return to IDLE with no output activity.
- **DATA**:
  - Sample at clock count `P_CLKS_PER_BIT`-1 and wrap the counter to 0.
  - Shift the sample in and accumulate an XOR of the data bits.
  - After `P_DATA_BITS` samples, go to PARITY if `P_PARITY`≠0, else STOP.
- **PARITY**:
  - One sample; the parity error is latched into an internal flag.
  - Error rule: odd mode errors when XOR(data, bit)=0; even mode errors when XOR(data, bit)=1.
- **STOP**:
  - `P_STOP_BITS` samples; any low sample latches an internal frame-error flag.
  - On the last sample, register `o_DATA`, `o_PARITY_ERR` and `o_FRAME_ERR`, and pulse `o_RX_DONE`.
  - Next state: WAIT_HIGH if the frame-error flag is set, else IDLE.
- **WAIT_HIGH**: stay until `rx_s`=1, then go to IDLE. This prevents a held-low line (break) from retriggering.
- **Back-to-back frames**: a start bit immediately following the final stop bit is accepted; IDLE is reached mid-stop-bit, before the next falling edge.
- **Reset**:
  - Asserting `i_RST_N` low at any time forces IDLE and discards any partial frame.
  - Reset values: `o_DATA`=0, `o_RX_DONE`=0, `o_PARITY_ERR`=0, `o_FRAME_ERR`=0, `o_BUSY`=0; synchroniser=1.
- **Error flags**: the output flags are overwritten on each `o_RX_DONE` and are not sticky across frames.

## Timing
- Let edge e be the first `i_CLK` edge that samples `i_RX`=0 at the start bit.
  - IDLE sees `rx_s`=0 at edge e+2, and `o_BUSY` rises after that edge.
  - The start-bit sample is taken at edge e+2+H.
- Let C = `P_CLKS_PER_BIT` and F = `P_DATA_BITS` + (`P_PARITY`≠0) + `P_STOP_BITS`.
  - The data/parity/stop sample k (k = 1..F) is taken at edge e+2+H+k·C.
  - `o_RX_DONE` is high during the cycle following edge e+2+H+F·C.
- Defaults (8N1, C=16): `o_RX_DONE` follows edge e+154, and `o_BUSY` drops at the same edge.
- `o_RX_DONE` is never high for two consecutive cycles. The minimum spacing between pulses is F·C + C cycles for back-to-back frames.

## Test plan
- **Default 8N1 frame**: defaults, send 0xA5 with bits held exactly 16 cycles → `o_DATA`=0xA5 and one `o_RX_DONE` pulse 154 cycles after the falling edge; `o_PARITY_ERR`=0 and `o_FRAME_ERR`=0.
- **False start**: drive `i_RX` low for 4 cycles, then high → no `o_RX_DONE`; `o_BUSY` returns to 0 within 12 cycles.
- **Framing error and recovery**: send 0x3C with the stop bit low, holding the line low for 40 more cycles → `o_RX_DONE` with `o_FRAME_ERR`=1 and no second pulse while the line is low. Then release high and send 0x81 → `o_DATA`=0x81, `o_FRAME_ERR`=0.
- **Parity, even mode**: `P_PARITY`=2; send 0x07 with parity bit 1 → `o_PARITY_ERR`=0. Send 0x07 with parity bit 0 → `o_PARITY_ERR`=1 and `o_DATA`=0x07.
- **Back-to-back, 2 stop bits**: `P_STOP_BITS`=2, `P_DATA_BITS`=7; send 0x00 then 0x7F with no idle gap → two pulses exactly 160 cycles apart, with `o_DATA` equal to 0x00 then 0x7F.
- **Reset mid-frame**: assert `i_RST_N` low for 1 cycle during data bit 3 of 0x55 → all outputs 0 immediately, no `o_RX_DONE` for that frame. A following frame 0xC3 is received correctly.
